mdu_alu_controller: RTL and testbench
=====================================

MDU_ALU_CONTROLLER -- requirements
Module: mdu_alu_controller

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be an even value >= 4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-005 Funct7  in  7  instruction bits 31:25.
REQ-006 Funct3  in  3  instruction bits 14:12.
REQ-007 RType  in  1  1 = R-type instruction (Funct7 meaningful).
REQ-008 Valid  in  1  instruction present in EX.
REQ-009 Flush  in  1  kill EX instruction this cycle.
REQ-010 SrcA, SrcB  in  XLEN  rs1/rs2 operands.
REQ-011 Operation  out  4  ALU operation select (combinational).
REQ-012 Stall  out  1  hold IF/ID/EX while M-unit computes (combinational).
REQ-013 MdDone  out  1  MdResult valid this cycle (registered state).
REQ-014 MdResult  out  XLEN  M-extension result.

Function
REQ-015 Operation encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 BEQ, 1001 BNE, 1010 BLT, 1011 BGE, 1100 SLT, 1101 BLTU, 1110 BGEU, 1111 SLTU.
REQ-016 ALUOp 00 or 11 SHALL give ADD regardless of Funct fields.
REQ-017 ALUOp 01 SHALL map Funct3 000/001/100/101/110/111 to BEQ/BNE/BLT/BGE/BLTU/BGEU; 010/011 give ADD.
REQ-018 ALUOp 10, Funct3 000: SUB iff RType and Funct7=0100000, else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA iff Funct7=0100000 else SRL; 110 OR; 111 AND.
REQ-019 MdReq = Valid & ALUOp=10 & RType & Funct7=0000001; Funct3 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-020 FSM states IDLE, BUSY, DONE.
REQ-021 IDLE & MdReq & !Flush: latch SrcA, SrcB, Funct3; go BUSY with counter = XLEN, or DONE directly for a special case (REQ-026/027).
REQ-022 BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle on operand magnitudes; counter decrements; at counter 1 go DONE.
REQ-023 DONE: MdDone=1 for exactly one cycle with final sign-corrected result; next state IDLE; no new request accepted in DONE.
REQ-024 Stall SHALL be 1 when (IDLE & MdReq & !Flush) or BUSY; 0 in DONE and otherwise. Normal latency: accept cycle + XLEN BUSY cycles, MdDone on cycle XLEN+1 after accept.
REQ-025 Signedness: MUL/MULH/DIV/REM both signed; MULHSU SrcA signed, SrcB unsigned; others unsigned. MUL returns low XLEN bits, MULH* high XLEN bits of the 2*XLEN product; REM sign follows dividend.
REQ-026 Divide by zero: DIV/DIVU quotient all ones, REM/REMU = dividend; via DONE in one cycle.
REQ-027 Signed overflow (SrcA=most negative, SrcB=-1): DIV = SrcA, REM = 0; via DONE in one cycle.
REQ-028 Flush in BUSY or DONE SHALL return FSM to IDLE next cycle, MdDone=0, result discarded; Flush in IDLE blocks acceptance.
REQ-029 MdResult SHALL hold last completed value outside DONE; operand inputs ignored after acceptance.

Reset
REQ-030 reset SHALL force IDLE, counter 0, MdDone 0, MdResult 0, internal operand/accumulator registers 0; reset overrides Flush and any in-flight operation.
REQ-031 Operation and Stall SHALL remain combinational; Stall=0 in the reset cycle's following IDLE unless MdReq.

Verification
REQ-032 ALUOp=10, RType=1, Funct7=0100000, Funct3=000 -> Operation=0110; same with RType=0 -> 0010; ALUOp=01, Funct3=101 -> 1011.
REQ-033 XLEN=32, MUL SrcA=7, SrcB=-3 -> Stall high 33 cycles, MdDone on cycle 33 after accept, MdResult=0xFFFFFFEB.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> MdResult=0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF after one Stall cycle; DIV 0x80000000/-1 -> 0x80000000.
REQ-036 Flush asserted at BUSY cycle 10 -> IDLE next cycle, no MdDone, Stall 0; new DIVU 100/7 accepted afterwards -> 14.
REQ-037 reset asserted mid-BUSY -> next cycle IDLE, MdDone=0, MdResult=0, Stall=0 with Valid=0.

Source files
------------

// File: rtl/mdu_alu_controller.sv
// ALU operation decoder plus iterative RV32M multiply/divide unit.
//
// State table:
//   state  | meaning
//   IDLE   | waiting; accepts an M-extension request unless Flush is high
//   BUSY   | one shift-add or restoring-subtract step per cycle, counter counts down
//   DONE   | MdDone high for one cycle; MdResult holds the final result
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ALUOp, Funct7,      instruction class and function fields used for decoding
//   Funct3, RType
//   Valid, Flush        instruction present in EX / kill the EX instruction
//   SrcA, SrcB          rs1 / rs2 operands, sampled only on acceptance
//   Operation           ALU operation select (combinational)
//   Stall               hold IF/ID/EX while the M-unit works (combinational)
//   MdDone, MdResult    registered M-unit result strobe and value
module mdu_alu_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            RType,
    input  logic            Valid,
    input  logic            Flush,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [3:0]      Operation,
    output logic            Stall,
    output logic            MdDone,
    output logic [XLEN-1:0] MdResult
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010,
                           OP_XOR  = 4'b0011, OP_SLL  = 4'b0100, OP_SRL  = 4'b0101,
                           OP_SUB  = 4'b0110, OP_SRA  = 4'b0111, OP_BEQ  = 4'b1000,
                           OP_BNE  = 4'b1001, OP_BLT  = 4'b1010, OP_BGE  = 4'b1011,
                           OP_SLT  = 4'b1100, OP_BLTU = 4'b1101, OP_BGEU = 4'b1110,
                           OP_SLTU = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;       // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;       // multiplier / dividend, becomes product low / quotient
    logic [XLEN-1:0]   dvs_q, dvs_d;     // multiplicand or divisor magnitude
    logic [2:0]        op_q, op_d;
    logic              neg_main_q, neg_main_d;   // negate product / quotient
    logic              neg_rem_q, neg_rem_d;     // negate remainder (dividend sign)
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    always_comb begin
        Operation = OP_ADD;
        case (ALUOp)
            2'b01: begin
                case (Funct3)
                    3'b000:  Operation = OP_BEQ;
                    3'b001:  Operation = OP_BNE;
                    3'b100:  Operation = OP_BLT;
                    3'b101:  Operation = OP_BGE;
                    3'b110:  Operation = OP_BLTU;
                    3'b111:  Operation = OP_BGEU;
                    default: Operation = OP_ADD;
                endcase
            end
            2'b10: begin
                case (Funct3)
                    3'b000:  Operation = (RType && Funct7 == 7'b0100000) ? OP_SUB : OP_ADD;
                    3'b001:  Operation = OP_SLL;
                    3'b010:  Operation = OP_SLT;
                    3'b011:  Operation = OP_SLTU;
                    3'b100:  Operation = OP_XOR;
                    3'b101:  Operation = (Funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
                    3'b110:  Operation = OP_OR;
                    default: Operation = OP_AND;
                endcase
            end
            default: Operation = OP_ADD;
        endcase
    end

    logic              md_req, sign_a, sign_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, quot_s, rem_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        md_req   = Valid && (ALUOp == 2'b10) && RType && (Funct7 == 7'b0000001);
        // Signed rs1: MUL, MULH, MULHSU, DIV, REM. Signed rs2: MUL, MULH, DIV, REM.
        sign_a   = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        sign_b   = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        neg_a    = sign_a && SrcA[XLEN-1];
        neg_b    = sign_b && SrcB[XLEN-1];
        a_mag    = neg_a ? -SrcA : SrcA;
        b_mag    = neg_b ? -SrcB : SrcB;
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (SrcB == '1);

        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, dvs_q};
        if (op_q[2]) begin
            // Restoring divide: keep the trial difference only when it did not borrow.
            step_hi = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod_s = neg_main_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quot_s = neg_main_q ? -step_lo : step_lo;
        rem_s  = neg_rem_q  ? -step_hi : step_hi;
        case (op_q)
            3'b000:         final_res = prod_s[XLEN-1:0];
            3'b100, 3'b101: final_res = quot_s;
            3'b110, 3'b111: final_res = rem_s;
            default:        final_res = prod_s[2*XLEN-1:XLEN];
        endcase

        Stall = (state_q == S_BUSY) || ((state_q == S_IDLE) && md_req && !Flush);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dvs_d      = dvs_q;
        op_d       = op_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        done_d     = 1'b0;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (md_req && !Flush) begin
                    op_d       = Funct3;
                    neg_main_d = neg_a ^ neg_b;
                    neg_rem_d  = neg_a;
                    if (div_zero) begin
                        result_d = Funct3[1] ? SrcA : '1;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end else if (div_ovf) begin
                        result_d = Funct3[1] ? '0 : SrcA;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end else begin
                        hi_d    = '0;
                        lo_d    = Funct3[2] ? a_mag : b_mag;
                        dvs_d   = Funct3[2] ? b_mag : a_mag;
                        cnt_d   = CW'(XLEN);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (Flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dvs_q      <= '0;
            op_q       <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dvs_q      <= dvs_d;
            op_q       <= op_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign MdDone   = done_q;
    assign MdResult = result_q;

endmodule

// File: tb/tb_mdu_alu_controller.sv
module tb_mdu_alu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic        RType, Valid, Flush;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        Stall, MdDone;
    logic [31:0] MdResult;

    mdu_alu_controller #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .RType(RType), .Valid(Valid), .Flush(Flush), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .Stall(Stall), .MdDone(MdDone), .MdResult(MdResult)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [1:0] aluop;
        logic       rtype;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] exp;
    } op_vec_t;

    op_vec_t op_tab [21] = '{
        '{2'b10, 1'b1, 7'h20, 3'd0, 4'b0110},
        '{2'b10, 1'b0, 7'h20, 3'd0, 4'b0010},
        '{2'b10, 1'b1, 7'h00, 3'd0, 4'b0010},
        '{2'b01, 1'b0, 7'h00, 3'd5, 4'b1011},
        '{2'b00, 1'b1, 7'h20, 3'd0, 4'b0010},
        '{2'b11, 1'b1, 7'h20, 3'd7, 4'b0010},
        '{2'b01, 1'b0, 7'h00, 3'd0, 4'b1000},
        '{2'b01, 1'b0, 7'h00, 3'd1, 4'b1001},
        '{2'b01, 1'b0, 7'h00, 3'd4, 4'b1010},
        '{2'b01, 1'b0, 7'h00, 3'd6, 4'b1101},
        '{2'b01, 1'b0, 7'h00, 3'd7, 4'b1110},
        '{2'b01, 1'b0, 7'h00, 3'd2, 4'b0010},
        '{2'b10, 1'b1, 7'h20, 3'd5, 4'b0111},
        '{2'b10, 1'b0, 7'h00, 3'd5, 4'b0101},
        '{2'b10, 1'b0, 7'h20, 3'd5, 4'b0111},
        '{2'b10, 1'b1, 7'h00, 3'd1, 4'b0100},
        '{2'b10, 1'b0, 7'h00, 3'd2, 4'b1100},
        '{2'b10, 1'b0, 7'h00, 3'd3, 4'b1111},
        '{2'b10, 1'b0, 7'h00, 3'd4, 4'b0011},
        '{2'b10, 1'b0, 7'h00, 3'd6, 4'b0001},
        '{2'b10, 1'b0, 7'h00, 3'd7, 4'b0000}
    };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0:    begin p = 64'(sa * sb); return p[31:0]; end
            3'd1:    begin p = 64'(sa * sb); return p[63:32]; end
            3'd2:    begin p = 64'(sa * ub); return p[63:32]; end
            3'd3:    begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Issue one M-extension request (called 1 time unit after a rising edge),
    // then follow it to MdDone and check latency, stall count and result.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int          cyc;
        int          stl;
        logic [31:0] exp_v;
        exp_q.push_back(exp_res);
        Valid = 1'b1; ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'h01;
        Funct3 = f3; SrcA = a; SrcB = b; Flush = 1'b0;
        #1;
        stl = Stall ? 1 : 0;
        @(posedge clk); #1;
        Valid = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
        cyc = 1;
        while (MdDone !== 1'b1 && cyc < 100) begin
            #1;
            if (Stall) stl++;
            @(posedge clk); #1;
            cyc++;
        end
        exp_v = exp_q.pop_front();
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(stl), 64'(exp_lat));
        chk({tag, "_result"}, {32'h0, MdResult}, {32'h0, exp_v});
        #1;
        chk({tag, "_stall_in_done"}, {63'h0, Stall}, 64'h0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {63'h0, MdDone}, 64'h0);
        chk({tag, "_hold"}, {32'h0, MdResult}, {32'h0, exp_v});
    endtask

    initial begin
        int          seen;
        logic [31:0] prev;
        logic [31:0] ra, rb;
        reset = 1'b1; ALUOp = 2'b00; Funct7 = 7'h00; Funct3 = 3'd0; RType = 1'b0;
        Valid = 1'b0; Flush = 1'b0; SrcA = 32'h0; SrcB = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_done", {63'h0, MdDone}, 64'h0);
        chk("rst_result", {32'h0, MdResult}, 64'h0);
        chk("rst_stall", {63'h0, Stall}, 64'h0);

        foreach (op_tab[i]) begin
            ALUOp = op_tab[i].aluop; RType = op_tab[i].rtype;
            Funct7 = op_tab[i].f7; Funct3 = op_tab[i].f3;
            #1;
            chk($sformatf("operation_%0d", i), {60'h0, Operation}, {60'h0, op_tab[i].exp});
        end
        @(posedge clk); #1;

        run_md("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md("mulhu_ff",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("mulh_ff",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_md("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_md("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_md("divu_5_0",    3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_md("rem_5_0",     3'd6, 32'd5,          32'd0,         32'd5,         1);
        run_md("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
        run_md("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            run_md($sformatf("rand_f3_%0d", i), 3'(i), ra, rb, ref_md(3'(i), ra, rb),
                   ref_lat(3'(i), ra, rb));
        end

        // Flush while idle blocks acceptance.
        Valid = 1'b1; ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'h01; Funct3 = 3'd0;
        SrcA = 32'd3; SrcB = 32'd4; Flush = 1'b1;
        #1;
        chk("flush_idle_stall", {63'h0, Stall}, 64'h0);
        @(posedge clk); #1;
        Valid = 1'b0; Flush = 1'b0;
        #1;
        chk("flush_idle_not_busy", {63'h0, Stall}, 64'h0);
        @(posedge clk); #1;

        // Flush at BUSY cycle 10 discards the operation.
        prev = MdResult;
        Valid = 1'b1; ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'h01; Funct3 = 3'd5;
        SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge clk); #1;
        Valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        Flush = 1'b1;
        @(posedge clk); #1;
        Flush = 1'b0;
        #1;
        chk("flush_busy_done", {63'h0, MdDone}, 64'h0);
        chk("flush_busy_stall", {63'h0, Stall}, 64'h0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (MdDone) seen++; end
        chk("flush_busy_no_done", 64'(seen), 64'h0);
        chk("flush_busy_hold", {32'h0, MdResult}, {32'h0, prev});
        run_md("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // Reset in the middle of BUSY.
        Valid = 1'b1; ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'h01; Funct3 = 3'd0;
        SrcA = 32'd9; SrcB = 32'd9;
        @(posedge clk); #1;
        Valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_done", {63'h0, MdDone}, 64'h0);
        chk("midrst_result", {32'h0, MdResult}, 64'h0);
        chk("midrst_stall", {63'h0, Stall}, 64'h0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (MdDone) seen++; end
        chk("midrst_no_done", 64'(seen), 64'h0);
        run_md("after_rst_mul", 3'd0, 32'd9, 32'd9, 32'd81, 33);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
